// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: streams weight/activation pairs into a MAC per neuron and captures each dot product
module mac_operand_sequencer #(
  parameter int N_INPUTS = 4,
  parameter int N_NEURONS = 2,
  parameter int WAW = (N_INPUTS * N_NEURONS > 1) ? $clog2(N_INPUTS * N_NEURONS) : 1,
  parameter int AAW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
  localparam int RIW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic           clk_x70,
  input  logic           reset_x70,
  input  logic           start_x70,
  output logic           busy_x70,
  output logic           done_x70,
  output logic [WAW-1:0] w_addr_x70,
  input  logic [31:0]    w_data_x70,
  output logic [AAW-1:0] a_addr_x70,
  input  logic [31:0]    a_data_x70,
  output logic [31:0]    mac_inp1_x70,
  output logic [31:0]    mac_inp2_x70,
  output logic           mac_reset_x70,
  input  logic [31:0]    mac_out_x70,
  output logic           res_valid_x70,
  output logic [31:0]    res_data_x70,
  output logic [RIW-1:0] res_idx_x70
);
  localparam logic [1:0] IDLE = 2'd0, CLR = 2'd1, RUN = 2'd2, CAP = 2'd3;
  logic [1:0] state_q, state_d, p_q, p_d;
  logic [AAW-1:0] k_q, k_d, a_nxt;
  logic [RIW-1:0] j_q, j_d, res_idx_q;
  logic [31:0] inp1_q, inp2_q, res_data_q;
  logic res_valid_q, done_q, in_run, cap, last_k, last_j;
  // next state, frame phase, input/neuron counters and the address to present this cycle
  always_comb begin
    in_run = state_q == RUN;
    cap = state_q == CAP;
    last_k = k_q == AAW'(N_INPUTS - 1);
    last_j = j_q == RIW'(N_NEURONS - 1);
    state_d = state_q == IDLE ? (start_x70 ? CLR : IDLE) :
              state_q == CLR  ? RUN :
              in_run          ? ((p_q == 2'd2 && last_k) ? CAP : RUN) :
                                (last_j ? IDLE : CLR);
    p_d = (in_run && p_q != 2'd2) ? p_q + 2'd1 : 2'd0;
    a_nxt = (in_run && p_q == 2'd2 && !last_k) ? k_q + AAW'(1) : k_q;
    k_d = in_run ? a_nxt : '0;
    j_d = cap ? (last_j ? '0 : j_q + RIW'(1)) : j_q;
  end
  assign busy_x70 = state_q != IDLE;
  assign mac_reset_x70 = state_q == IDLE || state_q == CLR;
  assign a_addr_x70 = a_nxt;
  assign w_addr_x70 = WAW'(int'(j_q) * N_INPUTS + int'(a_nxt));
  assign mac_inp1_x70 = inp1_q;
  assign mac_inp2_x70 = inp2_q;
  assign res_valid_x70 = res_valid_q;
  assign res_data_x70 = res_data_q;
  assign res_idx_x70 = res_idx_q;
  assign done_x70 = done_q;
  // state registers; operands load on the phase-0 edge, results on the CAP edge
  always_ff @(posedge clk_x70) begin
    if (!reset_x70) begin
      state_q <= IDLE;
      p_q <= '0;
      k_q <= '0;
      j_q <= '0;
      inp1_q <= '0;
      inp2_q <= '0;
      res_data_q <= '0;
      res_idx_q <= '0;
      res_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      k_q <= k_d;
      j_q <= j_d;
      if (in_run && p_q == 2'd0) begin
        inp1_q <= w_data_x70;
        inp2_q <= a_data_x70;
      end
      if (cap) begin
        res_data_q <= mac_out_x70;
        res_idx_q <= j_q;
      end
      res_valid_q <= cap;
      done_q <= cap && last_j;
    end
  end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: scoreboard bench with RAM and MAC models around the sequencer
module tb_mac_operand_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic busy, done, mac_rst, res_valid;
  logic [2:0] w_addr;
  logic [1:0] a_addr;
  logic [0:0] res_idx;
  logic [31:0] w_data, a_data, inp1, inp2, mac_out, res_data;
  logic busy_b, done_b, mac_rst_b, res_valid_b;
  logic [0:0] w_addr_b, a_addr_b, res_idx_b;
  logic [31:0] w_data_b, a_data_b, inp1_b, inp2_b, mac_out_b, res_data_b;
  logic [31:0] w_mem [8];
  logic [31:0] a_mem [4];

  mac_operand_sequencer #(.N_INPUTS(4), .N_NEURONS(2)) dut (
    .clk_x70(clk), .reset_x70(rst_n), .start_x70(start), .busy_x70(busy), .done_x70(done),
    .w_addr_x70(w_addr), .w_data_x70(w_data), .a_addr_x70(a_addr), .a_data_x70(a_data),
    .mac_inp1_x70(inp1), .mac_inp2_x70(inp2), .mac_reset_x70(mac_rst), .mac_out_x70(mac_out),
    .res_valid_x70(res_valid), .res_data_x70(res_data), .res_idx_x70(res_idx));

  mac_operand_sequencer #(.N_INPUTS(1), .N_NEURONS(1)) dut_b (
    .clk_x70(clk), .reset_x70(rst_n), .start_x70(start_b), .busy_x70(busy_b), .done_x70(done_b),
    .w_addr_x70(w_addr_b), .w_data_x70(w_data_b), .a_addr_x70(a_addr_b), .a_data_x70(a_data_b),
    .mac_inp1_x70(inp1_b), .mac_inp2_x70(inp2_b), .mac_reset_x70(mac_rst_b), .mac_out_x70(mac_out_b),
    .res_valid_x70(res_valid_b), .res_data_x70(res_data_b), .res_idx_x70(res_idx_b));

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    d = (f[30:23] == 8'd0) ? {f[31], 63'd0} : {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    return (d[62:0] == 63'd0) ? {d[63], 31'd0} : {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // synchronous-read RAMs, one cycle of latency
  always @(posedge clk) begin
    w_data <= w_mem[w_addr];
    a_data <= a_mem[a_addr];
    w_data_b <= (w_addr_b == 1'b0) ? 32'hBF800000 : 32'h0;
    a_data_b <= (a_addr_b == 1'b0) ? 32'h3F800000 : 32'h0;
  end

  // 3-phase MAC models: add on the phase-1 edge, publish on the phase-2 edge
  int ph, ph_b;
  real acc, acc_b;
  always @(posedge clk) begin
    if (mac_rst) begin
      ph <= 0; acc <= 0.0; mac_out <= '0;
    end else begin
      ph <= (ph == 2) ? 0 : ph + 1;
      if (ph == 1) acc <= acc + f2r(inp1) * f2r(inp2);
      if (ph == 2) mac_out <= r2f(acc);
    end
    if (mac_rst_b) begin
      ph_b <= 0; acc_b <= 0.0; mac_out_b <= '0;
    end else begin
      ph_b <= (ph_b == 2) ? 0 : ph_b + 1;
      if (ph_b == 1) acc_b <= acc_b + f2r(inp1_b) * f2r(inp2_b);
      if (ph_b == 2) mac_out_b <= r2f(acc_b);
    end
  end

  typedef struct {int cyc; logic [31:0] data; logic idx;} exp_t;
  exp_t q[$];
  int dq[$];

  // monitor: pops the scoreboard whenever a result or done pulse appears
  always @(negedge clk) begin
    if (res_valid) begin
      if (q.size() == 0) chk("spurious_res_valid", 32'(res_valid), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_idx", 32'(res_idx), 32'(e.idx));
        chk("res_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("spurious_done", 32'(done), 32'd0);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  task automatic chk_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", res_data, 0);
    chk("rst_idx", 32'(res_idx), 0);
    chk("rst_w_addr", 32'(w_addr), 0);
    chk("rst_a_addr", 32'(a_addr), 0);
    chk("rst_inp1", inp1, 0);
    chk("rst_inp2", inp2, 0);
    chk("rst_mac_reset", 32'(mac_rst), 1);
  endtask

  task automatic watch(input logic [31:0] e0, input logic [31:0] e1, input int pa, input int pb);
    int s, j, m, r, k, ea;
    for (int rel = 0; rel < 29; rel++) begin
      @(negedge clk);
      if (rel == 0) begin
        s = cyc;
        q.push_back('{s + 15, e0, 1'b0});
        q.push_back('{s + 29, e1, 1'b1});
        dq.push_back(s + 29);
      end
      start = (rel == 0 || rel == pa || rel == pb);
      chk("busy", 32'(busy), 32'(rel >= 1));
      if (rel == 0) chk("mac_reset_idle", 32'(mac_rst), 1);
      else begin
        j = (rel - 1) / 14;
        m = rel - 1 - 14 * j;
        r = m - 1;
        chk("mac_reset", 32'(mac_rst), 32'(m == 0));
        if (m <= 12) begin
          k = (m == 0) ? 0 : r / 3;
          ea = (m > 0 && r % 3 == 2 && k < 3) ? k + 1 : k;
          chk("a_addr", 32'(a_addr), ea);
          chk("w_addr", 32'(w_addr), 4 * j + ea);
        end
        if (m >= 2) begin
          k = (r - 1) / 3;
          chk("inp1", inp1, w_mem[4 * j + k]);
          chk("inp2", inp2, a_mem[k]);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (q.size() > 0 || dq.size() > 0); i++) @(negedge clk);
    chk("drain_timeout", 32'(q.size() + dq.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i < 8; i++) w_mem[i] = (i < 4) ? 32'h3F800000 : 32'h40000000;
    a_mem = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    chk("rst_b_busy", 32'(busy_b), 0);
    rst_n = 1'b1;
    watch(32'h40D00000, 32'h41500000, 3, 10);
    watch(32'h40D00000, 32'h41500000, -1, -1);
    drain();
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    watch(32'h40D00000, 32'h41500000, -1, -1);
    drain();
    for (int i = 0; i < 8; i++) w_mem[i] = (i < 4 && i % 2 == 0) ? 32'h3F800000 : 32'hBF800000;
    for (int i = 0; i < 4; i++) a_mem[i] = 32'h3F800000;
    watch(32'h00000000, 32'hC0800000, -1, -1);
    drain();
    @(negedge clk);
    start_b = 1'b1;
    for (int rel = 1; rel <= 7; rel++) begin
      @(negedge clk);
      start_b = 1'b0;
      chk("b_busy", 32'(busy_b), 32'(rel <= 5));
      chk("b_w_addr", 32'(w_addr_b), 0);
      chk("b_a_addr", 32'(a_addr_b), 0);
      chk("b_valid", 32'(res_valid_b), 32'(rel == 6));
      chk("b_done", 32'(done_b), 32'(rel == 6));
      if (rel == 5) chk("b_inp1", inp1_b, 32'hBF800000);
      if (rel == 6) begin
        chk("b_res_data", res_data_b, 32'hBF800000);
        chk("b_res_idx", 32'(res_idx_b), 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_operand_sequencer.md
# mac_operand_sequencer

Drives the `Mac` accumulator from the feeding side. For each output neuron it clears the MAC and streams weight/activation operand pairs out of two synchronous-read memories, one pair per 3-cycle MAC frame. It then captures the accumulated float32 dot product and emits it on a valid-pulsed result port. It sits between the layer's weight/activation RAMs and one `Mac` instance in the MLP inference datapath.

## Interface
- N_INPUTS, default 4: dot-product length per neuron (≥1).
- N_NEURONS, default 2: neurons per run (≥1).
- WAW, default $clog2(N_INPUTS*N_NEURONS): weight address width.
- AAW, default $clog2(N_INPUTS): activation address width (minimum 1).
- clk_x70 in 1: single clock, all logic on posedge.
- reset_x70 in 1: synchronous, active-low reset.
- start_x70 in 1: run request, sampled only in IDLE.
- busy_x70 out 1: high from CLR of neuron 0 through the last CAP.
- done_x70 out 1: one-cycle pulse at end of run.
- w_addr_x70 out WAW: weight RAM address, equal to j*N_INPUTS+k.
- w_data_x70 in 32: weight RAM data, valid the cycle after the address.
- a_addr_x70 out AAW: activation RAM address, equal to k.
- a_data_x70 in 32: activation RAM data, 1-cycle latency.
- mac_inp1_x70 out 32: operand to MAC inp1 (weight).
- mac_inp2_x70 out 32: operand to MAC inp2 (activation).
- mac_reset_x70 out 1: active-high reset to MAC.
- mac_out_x70 in 32: MAC accumulated sum.
- res_valid_x70 out 1: one-cycle pulse, result valid.
- res_data_x70 out 32: captured float32 sum.
- res_idx_x70 out $clog2(N_NEURONS) (min 1): neuron index j of res_data.

## Operation
- States:
  - IDLE: start → CLR.
  - CLR: 1 cycle → RUN.
  - RUN: 3*N_INPUTS cycles → CAP.
  - CAP: 1 cycle → CLR if j<N_NEURONS-1 (j++), else IDLE.
- mac_reset_x70 = 1 in reset, IDLE and CLR; 0 in RUN and CAP. The MAC phase counter restarts at 0 every neuron.
- RUN counters: phase p∈{0,1,2} and input index k∈[0,N_INPUTS-1]. p wraps 2→0 with k++; RUN exits after p=2 at k=N_INPUTS-1.
- Address k is driven in the cycle before operand k is loaded. Address 0 is driven in CLR; address k+1 is driven in RUN at p=2 of k.
- mac_inp1/mac_inp2 are registered from w_data/a_data at the edge closing the cycle with p=0. That edge coincides with the MAC's phase-0 edge. Operands then hold unchanged for the full frame (edges p0, p1-add, p2-latch).
- CAP: res_data_x70 ← mac_out_x70 and res_idx_x70 ← j at the closing edge. res_valid_x70 is high the following cycle.
- After the final CAP: done_x70 and the last res_valid_x70 pulse together in the first IDLE cycle. busy_x70 is 0 in that cycle.
- start_x70 in any non-IDLE state is ignored. start_x70 in the done cycle is accepted, giving CLR on the next cycle.
- The sequencer performs no arithmetic on operands. Data is passed bit-exact.

## Timing
- Reset values: busy 0, done 0, res_valid 0, res_data 0, res_idx 0, w_addr 0, a_addr 0, mac_inp1/2 0, mac_reset 1, state IDLE.
- Start sampled high at the end of cycle s:
  - CLR = s+1.
  - RUN = s+2 … s+1+3N.
  - CAP = s+2+3N.
- Neuron period is 3N+2 cycles. Result j is valid in cycle s+(j+1)(3N+2)+1.
- done in cycle s+N_NEURONS*(3N+2)+1.
- N_INPUTS=1: RUN is exactly 3 cycles, and only address 0 is ever issued.
- Reset low mid-run: at the next edge, go to IDLE with all outputs at reset values. This includes mac_reset=1, so the MAC clears too. A partial result is never emitted.

## Test plan
- Single neuron: N=4, NN=1, weights all 0x3F800000, activations {0x3F800000, 0x40000000, 0x40400000, 0x3F000000}, start at s=0 → res_valid at cycle 15, res_data=0x40D00000 (6.5), res_idx=0, done in the same cycle.
- Two neurons: second row of weights 0x40000000 → res 0x40D00000 idx 0 at cycle 15, res 0x41500000 (13.0) idx 1 at cycle 29, done at 29. busy is high in cycles 1–28.
- Operand alignment: check every RUN cycle that mac_inp1/2 change only on p=0 edges. Check that w_addr sequences 0..7 and a_addr sequences 0..3 twice.
- Cancellation/edge: N=1, weight 0xBF800000 (−1.0), activation 0x3F800000 → res_data=0xBF800000 at cycle 6. With N=2 and weights {0x3F800000, 0xBF800000}, activations both 0x3F800000 → res_data ±0.
- Start while busy: pulse start at cycles 3 and 10 → no effect, single done. Start in the done cycle → new CLR the next cycle.
- Reset mid-run: reset_x70 low during RUN at cycle 7 → next cycle all outputs at reset values, no res_valid. Restarting afterwards yields correct 0x40D00000.
